// File: rtl/oclib_uart_pkg.sv
// rtl/oclib_uart_pkg.sv - shared UART library constants and width helper
package oclib_uart_pkg;

    localparam int ErrorTimeout   = 0;
    localparam int ErrorStrayLast = 1;
    localparam int ArbErrorWidth  = 2;

    // Counter/index width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/oclib_uart_tx_arbiter_if.sv
// rtl/oclib_uart_tx_arbiter_if.sv - per-requester byte streams plus shared UART tx stream
interface oclib_uart_tx_arbiter_if #(
    parameter int Requesters = 4
) ();

    logic [Requesters*8-1:0] in_data;
    logic [Requesters-1:0]   in_valid;
    logic [Requesters-1:0]   in_last;
    logic [Requesters-1:0]   in_ready;
    logic [Requesters-1:0]   grant;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        output in_data, in_valid, in_last, tx_ready,
        input  in_ready, grant, tx_data, tx_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, tx_ready,
        output in_ready, grant, tx_data, tx_valid
    );

endinterface

// File: rtl/oclib_rr_arbiter.sv
// rtl/oclib_rr_arbiter.sv - round-robin pick: first request at or above pointer, with wrap
module oclib_rr_arbiter
    import oclib_uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_request,
    input  logic [IW-1:0] i_pointer,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index,
    output logic          o_hit
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    // Wrap is done by subtracting N, so non-power-of-2 N works.
    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_hit   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_pointer} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!o_hit && i_request[w_idx]) begin
                o_hit          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_index        = w_idx;
            end
        end
    end

endmodule

// File: rtl/oclib_uart_tx_arbiter.sv
// rtl/oclib_uart_tx_arbiter.sv - message-granular round-robin share of one UART tx byte stream
module oclib_uart_tx_arbiter
    import oclib_uart_pkg::*;
#(
    parameter int Requesters    = 4,
    parameter int GapCycles     = 0,
    parameter int TimeoutCycles = 65536,
    parameter int ErrorWidth    = ArbErrorWidth
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear_error,
    output logic [ErrorWidth-1:0] o_error,
    oclib_uart_tx_arbiter_if.slave bus
);

    localparam int PtrW = clog2_min1(Requesters);
    localparam int WdW  = clog2_min1(TimeoutCycles + 1);
    localparam int GapW = clog2_min1(GapCycles + 1);

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_t;

    logic [1:0]            r_reset_sync;
    logic                  w_rst_n;
    state_t                r_state, w_state;
    logic [Requesters-1:0] r_grant, w_grant;
    logic [PtrW-1:0]       r_index, w_index;
    logic [PtrW-1:0]       r_ptr, w_ptr;
    logic [WdW-1:0]        r_wd, w_wd;
    logic [GapW-1:0]       r_gap, w_gap;
    logic [7:0]            r_tx_data, w_tx_data;
    logic                  r_tx_valid, w_tx_valid;
    logic [ErrorWidth-1:0] r_error, w_error;

    logic                  w_can_load, w_active, w_accept, w_timeout, w_stray, w_release;
    logic                  w_owner_valid, w_owner_last;
    logic [7:0]            w_owner_data;
    logic [Requesters-1:0] w_pick_grant;
    logic [PtrW-1:0]       w_pick_index;
    logic                  w_pick_hit;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_reset_sync <= '0;
        end else begin
            r_reset_sync <= {r_reset_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_reset_sync[1];

    oclib_rr_arbiter #(
        .N  (Requesters),
        .IW (PtrW)
    ) u_rr (
        .i_request (bus.in_valid),
        .i_pointer (r_ptr),
        .o_grant   (w_pick_grant),
        .o_index   (w_pick_index),
        .o_hit     (w_pick_hit)
    );

    assign w_can_load    = !r_tx_valid || bus.tx_ready;
    assign w_active      = (r_state == StActive);
    assign w_owner_valid = bus.in_valid[r_index];
    assign w_owner_last  = bus.in_last[r_index];
    assign w_owner_data  = bus.in_data[8*r_index +: 8];
    assign w_accept      = w_active && w_owner_valid && w_can_load;
    // Terminal count is the TimeoutCycles-th consecutive idle cycle of the owner.
    assign w_timeout     = w_active && !w_owner_valid && (TimeoutCycles != 0)
                           && (r_wd == WdW'(TimeoutCycles - 1));
    assign w_stray       = w_active && (|(bus.in_valid & bus.in_last & ~r_grant));

    assign bus.in_ready  = (w_active && w_can_load) ? r_grant : '0;
    assign bus.grant     = r_grant;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign o_error       = r_error;

    always_ff @(posedge i_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_index    <= '0;
            r_ptr      <= '0;
            r_wd       <= '0;
            r_gap      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_error    <= '0;
        end else begin
            r_state    <= w_state;
            r_grant    <= w_grant;
            r_index    <= w_index;
            r_ptr      <= w_ptr;
            r_wd       <= w_wd;
            r_gap      <= w_gap;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_error    <= w_error;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_grant    = r_grant;
        w_index    = r_index;
        w_ptr      = r_ptr;
        w_wd       = r_wd;
        w_gap      = r_gap;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_release  = 1'b0;

        w_error = i_clear_error ? '0 : r_error;
        if (w_timeout) begin
            w_error[ErrorTimeout] = 1'b1;
        end
        if (w_stray) begin
            w_error[ErrorStrayLast] = 1'b1;
        end

        if (w_can_load) begin
            w_tx_valid = w_accept;
            if (w_accept) begin
                w_tx_data = w_owner_data;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (w_pick_hit) begin
                    w_state = StActive;
                    w_grant = w_pick_grant;
                    w_index = w_pick_index;
                    w_wd    = '0;
                end
            end
            StActive: begin
                if (w_accept) begin
                    w_wd      = '0;
                    w_release = w_owner_last;
                end else if (w_timeout) begin
                    w_release = 1'b1;
                end else if (!w_owner_valid) begin
                    w_wd = r_wd + 1'b1;
                end
                if (w_release) begin
                    w_grant = '0;
                    w_ptr   = (r_index == PtrW'(Requesters - 1)) ? '0 : r_index + 1'b1;
                    w_gap   = '0;
                    w_state = (GapCycles > 0) ? StGap : StIdle;
                end
            end
            StGap: begin
                w_gap = r_gap + 1'b1;
                if (r_gap == GapW'(GapCycles - 1)) begin
                    w_state = StIdle;
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_oclib_uart_tx_arbiter.sv
// tb/tb_oclib_uart_tx_arbiter.sv - directed bench with message-level reference model
module tb_oclib_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 5;
    localparam int TMO = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr   = 1'b0;
    logic [1:0] error;

    always #5 clk = ~clk;

    oclib_uart_tx_arbiter_if #(.Requesters(N)) bus ();

    oclib_uart_tx_arbiter #(
        .Requesters    (N),
        .GapCycles     (GAP),
        .TimeoutCycles (TMO),
        .ErrorWidth    (2)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_clear_error (clr),
        .o_error       (error),
        .bus           (bus)
    );

    beat_t      src_q [N][$];
    bit         hold [N];
    bit         tb_tx_ready = 1'b1;
    bit         tb_clear    = 1'b0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference: owner index (-1 = none), next search start, gap cycles left, owner idle run.
    int         m_owner = -1;
    int         m_rr    = 0;
    int         m_gap   = 0;
    int         m_idle  = 0;
    int         m_rs    = 0;
    bit         m_txv   = 1'b0;
    logic [7:0] m_txd   = 8'h00;
    logic [1:0] m_err   = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         can_load, acc, done, timeout, stray, found;
        logic [7:0] byte_in;
        can_load = !m_txv || bus.tx_ready;
        acc = 0; done = 0; timeout = 0; stray = 0; found = 0; byte_in = 8'h00;
        if (m_owner >= 0) begin
            for (int i = 0; i < N; i++) begin
                if (i != m_owner && bus.in_valid[i] && bus.in_last[i]) stray = 1;
            end
            if (bus.in_valid[m_owner] && can_load) begin
                acc     = 1;
                byte_in = bus.in_data[8*m_owner +: 8];
                m_idle  = 0;
                done    = bus.in_last[m_owner];
            end else if (!bus.in_valid[m_owner]) begin
                m_idle++;
                if (m_idle == TMO) begin
                    timeout = 1;
                    done    = 1;
                end
            end
            if (done) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && bus.in_valid[(m_rr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_rr + k) % N;
                    m_idle  = 0;
                end
            end
        end
        if (can_load) begin
            m_txv = acc;
            if (acc) m_txd = byte_in;
        end
        if (clr) m_err = 2'b00;
        m_err = m_err | {stray, timeout};
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_rr = 0; m_gap = 0; m_idle = 0; m_rs = 0;
            m_txv = 1'b0; m_txd = 8'h00; m_err = 2'b00;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.in_valid[i] && bus.in_ready[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
            end
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
            if (m_rs >= 2) model_step();
            if (m_rs < 2) m_rs++;
        end
    end

    task automatic compare_outputs();
        logic [N-1:0] eg, er;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        er = (m_owner >= 0 && (!m_txv || bus.tx_ready)) ? eg : '0;
        check("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        if (m_txv) check("tx_data", 32'(bus.tx_data), 32'(m_txd));
        check("grant", 32'(bus.grant), 32'(eg));
        check("in_ready", 32'(bus.in_ready), 32'(er));
        check("error", 32'(error), 32'(m_err));
    endtask

    always @(negedge clk) begin
        logic [N*8-1:0] d;
        logic [N-1:0]   v, l;
        d = '0; v = '0; l = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                d[8*i +: 8] = src_q[i][0].data;
                l[i]        = src_q[i][0].last;
                v[i]        = !hold[i];
            end
        end
        bus.in_data  = d;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.tx_ready = tb_tx_ready;
        clr          = tb_clear;
        #1;
        compare_outputs();
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[r].push_back(b);
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int  n;
        bit  busy;
        n = 0;
        busy = 1;
        while (busy && n < budget) begin
            busy = (bus.tx_valid !== 1'b0) || (bus.grant !== '0);
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1;
            if (busy) begin
                tick();
                n++;
            end
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
        tick(GAP + 3);
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] g, input int budget);
        int n;
        n = 0;
        while (bus.grant !== g && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(bus.grant), 32'(g));
    endtask

    task automatic wait_got(input string name, input int cnt, input int budget);
        int n;
        n = 0;
        while (got_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(got_q.size() >= cnt), 32'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        bus.in_data  = '0;
        bus.in_valid = '0;
        bus.in_last  = '0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'(0));
        check("rst_tx_data", 32'(bus.tx_data), 32'(0));
        check("rst_grant", 32'(bus.grant), 32'(0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        rst_n = 1'b1;

        // Single requester, three-byte message.
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
        wait_idle(200);
        exp_q = '{8'h41, 8'h42, 8'h43};
        check_stream("t1_stream");
        check("t1_grant", 32'(bus.grant), 32'(0));
        check("t1_error", 32'(error), 32'(0));

        // Requesters 0 and 2 contend from reset; repeat starts again at 0.
        do_reset();
        push(0, 8'h10, 0); push(0, 8'h11, 1);
        push(2, 8'h20, 0); push(2, 8'h21, 1);
        wait_idle(300);
        push(0, 8'h12, 0); push(0, 8'h13, 1);
        push(2, 8'h22, 0); push(2, 8'h23, 1);
        wait_idle(300);
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
        check_stream("t2_order");

        // Requester 1 stalls mid-message and is evicted; requester 3 follows.
        do_reset();
        push(1, 8'h50, 0); push(1, 8'h51, 1);
        push(3, 8'h60, 1);
        cnt = 0;
        while (src_q[1].size() != 1 && cnt < 100) begin
            tick();
            cnt++;
        end
        hold[1] = 1'b1;
        cnt = 0;
        while (bus.grant[1] === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("t3_hold_cycles", 32'(cnt), 32'(16));
        check("t3_grant_dropped", 32'(bus.grant), 32'(0));
        check("t3_error", 32'(error), 32'(3));
        wait_grant("t3_grant3", 4'b1000, 50);
        tb_clear = 1'b1;
        tick();
        tb_clear = 1'b0;
        tick();
        check("t3_error_clr", 32'(error), 32'(0));
        hold[1] = 1'b0;
        wait_idle(200);
        exp_q = '{8'h50, 8'h60, 8'h51};
        check_stream("t3_stream");

        // Downstream stall for 10 cycles mid-message.
        push(0, 8'h70, 0); push(0, 8'h71, 0); push(0, 8'h72, 0); push(0, 8'h73, 1);
        wait_got("t4_first", 1, 50);
        tb_tx_ready = 1'b0;
        tick(10);
        check("t4_stall_valid", 32'(bus.tx_valid), 32'(1));
        check("t4_stall_data", 32'(bus.tx_data), 32'(8'h71));
        check("t4_stall_ready", 32'(bus.in_ready), 32'(0));
        tb_tx_ready = 1'b1;
        wait_idle(200);
        exp_q = '{8'h70, 8'h71, 8'h72, 8'h73};
        check_stream("t4_stream");
        check("t4_error", 32'(error), 32'(0));

        // Gap between back-to-back messages: 5 gap cycles plus the pick cycle.
        push(1, 8'h80, 1);
        push(2, 8'h90, 1);
        wait_grant("t5_grant1", 4'b0010, 50);
        wait_grant("t5_release", 4'b0000, 50);
        cnt = 0;
        while (bus.grant === '0 && cnt < 50) begin
            cnt++;
            tick();
        end
        check("t5_zero_grant_cycles", 32'(cnt), 32'(6));
        check("t5_grant2", 32'(bus.grant), 32'(4'b0100));
        wait_idle(200);
        exp_q = '{8'h80, 8'h90};
        check_stream("t5_stream");

        // Asynchronous reset mid-message, then arbitration restarts at 0.
        push(2, 8'hA0, 0); push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
        wait_got("t6_first", 1, 50);
        tb_tx_ready = 1'b0;
        tick(2);
        check("t6_pre_valid", 32'(bus.tx_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.tx_valid), 32'(0));
        check("t6_async_grant", 32'(bus.grant), 32'(0));
        check("t6_async_ready", 32'(bus.in_ready), 32'(0));
        for (int i = 0; i < N; i++) src_q[i].delete();
        got_q.delete();
        tick(2);
        rst_n = 1'b1;
        tb_tx_ready = 1'b1;
        push(1, 8'hB1, 1);
        push(0, 8'hB0, 1);
        wait_idle(200);
        exp_q = '{8'hB0, 8'hB1};
        check_stream("t6_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
